// File: rtl/number_to_ascii.sv
// Serializes a signed integer into an ASCII decimal byte stream: optional '-', digits without
// leading zeros, optional terminator. The binary-to-BCD step is double-dabble, one bit per cycle.
module number_to_ascii #(
    parameter int         NUM_BITS   = 16,
    parameter int         MAX_DIGITS = 5,
    parameter int         TERM_EN    = 1,
    parameter logic [7:0] TERM_CHAR  = 8'h0A
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] num_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [7:0]          char_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                last
);

    localparam int BCD_W = 4 * MAX_DIGITS;
    localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int CNT_W = $clog2(NUM_BITS + 1);

    typedef enum logic [2:0] {IDLE, CONVERT, SIGN, DIGITS, TERM} state_t;

    state_t              state_q;
    logic                neg_q;
    logic [NUM_BITS-1:0] mag_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [7:0]          char_q;
    logic                valid_q;
    logic                last_q;
    logic                ready_q;

    logic [BCD_W-1:0]    bcdAdj;
    logic [BCD_W-1:0]    bcd_d;
    logic [NUM_BITS-1:0] mag_d;
    logic [IDX_W-1:0]    firstIdx;

    function automatic logic [7:0] asciiDigit(input logic [BCD_W-1:0] b, input logic [IDX_W-1:0] i);
        return 8'h30 | {4'h0, b[4*i +: 4]};
    endfunction

    // One double-dabble step, plus the most significant nonzero digit of the shifted result
    always_comb begin
        bcdAdj   = '0;
        firstIdx = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcdAdj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
        bcd_d = {bcdAdj[BCD_W-2:0], mag_q[NUM_BITS-1]};
        mag_d = {mag_q[NUM_BITS-2:0], 1'b0};
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (bcd_d[4*i +: 4] != 4'd0) firstIdx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            neg_q   <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        neg_q   <= num_in[NUM_BITS-1];
                        // Unsigned magnitude: the most negative value maps cleanly to 2^(N-1)
                        mag_q   <= num_in[NUM_BITS-1] ? (~num_in + 1'b1) : num_in;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(NUM_BITS);
                        ready_q <= 1'b0;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        idx_q   <= firstIdx;
                        valid_q <= 1'b1;
                        if (neg_q) begin
                            char_q  <= 8'h2D;
                            last_q  <= 1'b0;
                            state_q <= SIGN;
                        end else begin
                            char_q  <= asciiDigit(bcd_d, firstIdx);
                            last_q  <= (firstIdx == '0) && (TERM_EN == 0);
                            state_q <= DIGITS;
                        end
                    end
                end
                SIGN: begin
                    if (out_ready) begin
                        char_q  <= asciiDigit(bcd_q, idx_q);
                        last_q  <= (idx_q == '0) && (TERM_EN == 0);
                        state_q <= DIGITS;
                    end
                end
                DIGITS: begin
                    if (out_ready) begin
                        if (idx_q == '0) begin
                            if (TERM_EN != 0) begin
                                char_q  <= TERM_CHAR;
                                last_q  <= 1'b1;
                                state_q <= TERM;
                            end else begin
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                ready_q <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else begin
                            idx_q  <= idx_q - 1'b1;
                            char_q <= asciiDigit(bcd_q, idx_q - 1'b1);
                            last_q <= (idx_q == IDX_W'(1)) && (TERM_EN == 0);
                        end
                    end
                end
                TERM: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign char_out  = char_q;
    assign out_valid = valid_q;
    assign last      = last_q;

endmodule

// File: tb/tb_number_to_ascii.sv
// Randomized bench for number_to_ascii: expected byte streams come from $sformatf("%0d") of the value.
// Instance 0 emits a newline terminator, instance 1 has the terminator disabled.
module tb_number_to_ascii;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] numIn[2];
    logic        inValid[2];
    logic        inReady[2];
    logic [7:0]  charOut[2];
    logic        outValid[2];
    logic        outReady[2];
    logic        last[2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    number_to_ascii #(.TERM_EN(1)) dut (
        .clk(clk), .reset(reset), .num_in(numIn[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .char_out(charOut[0]), .out_valid(outValid[0]), .out_ready(outReady[0]), .last(last[0])
    );

    number_to_ascii #(.TERM_EN(0)) dutNoTerm (
        .clk(clk), .reset(reset), .num_in(numIn[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .char_out(charOut[1]), .out_valid(outValid[1]), .out_ready(outReady[1]), .last(last[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Sends one number to instance s and checks the whole byte stream, latency and handshake rules
    task automatic applyStimulus(input int s, input int value, input bit randReady);
        logic [7:0] expQ[$];
        string      str;
        int         cyc;
        int         idx;
        int         guard;
        int         protoErr;
        bit         stalled;
        logic [7:0] held;
        logic       heldLast;
        str = $sformatf("%0d", value);
        for (int i = 0; i < str.len(); i++) expQ.push_back(str[i]);
        if (s == 0) expQ.push_back(8'h0A);
        checkOutput("readyBeforeAccept", {31'd0, inReady[s]}, 32'd1);
        numIn[s]    = value[15:0];
        inValid[s]  = 1'b1;
        outReady[s] = 1'b0;
        @(posedge clk); #1;
        inValid[s] = 1'b0;
        numIn[s]   = 16'($urandom);
        cyc = 1;
        protoErr = 0;
        while (!outValid[s] && cyc < 100) begin
            if (inReady[s]) protoErr++;
            inValid[s] = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        inValid[s] = 1'b0;
        checkOutput("firstByteLatency", cyc, 32'd17);
        if (!outValid[s]) return;
        idx = 0;
        guard = 0;
        stalled = 1'b0;
        held = '0;
        heldLast = 1'b0;
        while (idx < expQ.size() && guard < 500) begin
            outReady[s] = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inReady[s]) protoErr++;
            if (!outValid[s]) begin
                protoErr++;
            end else begin
                if (stalled) begin
                    checkOutput("charStableWhileStalled", {24'd0, charOut[s]}, {24'd0, held});
                    checkOutput("lastStableWhileStalled", {31'd0, last[s]}, {31'd0, heldLast});
                end
                if (outReady[s]) begin
                    checkOutput($sformatf("v%0d_byte%0d", value, idx), {24'd0, charOut[s]}, {24'd0, expQ[idx]});
                    checkOutput($sformatf("v%0d_last%0d", value, idx), {31'd0, last[s]},
                                (idx == expQ.size() - 1) ? 32'd1 : 32'd0);
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled  = 1'b1;
                    held     = charOut[s];
                    heldLast = last[s];
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        outReady[s] = 1'b0;
        checkOutput("streamComplete", idx, expQ.size());
        checkOutput("protocolErrors", protoErr, 32'd0);
        checkOutput("idleAfterStream", {30'd0, outValid[s], inReady[s]}, 32'd1);
    endtask

    // Reset asserted while '2' of 1234 is on the output must abort the stream at once
    task automatic abortStream();
        int guard;
        numIn[0]   = 16'd1234;
        inValid[0] = 1'b1;
        @(posedge clk); #1;
        inValid[0]  = 1'b0;
        outReady[0] = 1'b1;
        guard = 0;
        while (!(outValid[0] && charOut[0] == 8'h32) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("reachedDigitTwo", {24'd0, charOut[0]}, 32'h32);
        reset = 1'b1;
        #1;
        checkOutput("abortOutValid", {31'd0, outValid[0]}, 32'd0);
        checkOutput("abortInReady", {31'd0, inReady[0]}, 32'd1);
        checkOutput("abortLast", {31'd0, last[0]}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        outReady[0] = 1'b0;
        checkOutput("postAbortIdle", {31'd0, outValid[0]}, 32'd0);
        applyStimulus(0, 5, 1'b0);
    endtask

    initial begin
        logic [15:0] r;
        for (int i = 0; i < 2; i++) begin
            numIn[i]    = '0;
            inValid[i]  = 1'b0;
            outReady[i] = 1'b0;
        end
        #1 reset = 1'b1;
        #1;
        checkOutput("resetInReady", {31'd0, inReady[0]}, 32'd1);
        checkOutput("resetOutValid", {31'd0, outValid[0]}, 32'd0);
        checkOutput("resetLast", {31'd0, last[0]}, 32'd0);
        checkOutput("resetCharOut", {24'd0, charOut[0]}, 32'd0);
        checkOutput("resetNoTermReady", {31'd0, inReady[1]}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        applyStimulus(0, 0, 1'b0);
        applyStimulus(0, 1234, 1'b0);
        applyStimulus(0, -32768, 1'b0);
        applyStimulus(0, 32767, 1'b0);
        applyStimulus(0, -7, 1'b1);
        abortStream();
        applyStimulus(1, 9, 1'b0);
        applyStimulus(1, 10, 1'b0);
        applyStimulus(1, -32768, 1'b1);

        for (int n = 0; n < 24; n++) begin
            r = 16'($urandom);
            applyStimulus(n % 2, int'($signed(r)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
